// File: rtl/dmem_req_ctrl_if.sv
// dmem_req_ctrl_if
//   Bundles every handshake/bus signal of the data-memory request controller.
//   The controller is the bus master and uses the "master" modport. The
//   surrounding pipeline and memory (or a testbench) use the "slave" modport.
//   Signal groups:
//     mem1_req_*        : load/store request from the MEM1 issue stage
//     flush_i           : pipeline flush (exception / eret)
//     data_*            : SRAM-like bus (req / addr_ok / data_ok)
//     data_data_ok_o,
//     mem_rdata_o       : live response to MEM2
//     busy_o            : controller has work pending or in flight
interface dmem_req_ctrl_if;
   logic        mem1_req_valid_i;
   logic        mem1_req_wr_i;
   logic [1:0]  mem1_req_size_i;
   logic [31:0] mem1_req_addr_i;
   logic [3:0]  mem1_req_wstrb_i;
   logic [31:0] mem1_req_wdata_i;
   logic        mem1_req_ready_o;
   logic        flush_i;
   logic        data_req_o;
   logic        data_wr_o;
   logic [1:0]  data_size_o;
   logic [31:0] data_addr_o;
   logic [3:0]  data_wstrb_o;
   logic [31:0] data_wdata_o;
   logic        data_addr_ok_i;
   logic        data_data_ok_i;
   logic [31:0] data_rdata_i;
   logic        data_data_ok_o;
   logic [31:0] mem_rdata_o;
   logic        busy_o;

   modport master (
      input  mem1_req_valid_i, mem1_req_wr_i, mem1_req_size_i, mem1_req_addr_i,
             mem1_req_wstrb_i, mem1_req_wdata_i, flush_i,
             data_addr_ok_i, data_data_ok_i, data_rdata_i,
      output mem1_req_ready_o, data_req_o, data_wr_o, data_size_o, data_addr_o,
             data_wstrb_o, data_wdata_o, data_data_ok_o, mem_rdata_o, busy_o
   );

   modport slave (
      output mem1_req_valid_i, mem1_req_wr_i, mem1_req_size_i, mem1_req_addr_i,
             mem1_req_wstrb_i, mem1_req_wdata_i, flush_i,
             data_addr_ok_i, data_data_ok_i, data_rdata_i,
      input  mem1_req_ready_o, data_req_o, data_wr_o, data_size_o, data_addr_o,
             data_wstrb_o, data_wdata_o, data_data_ok_o, mem_rdata_o, busy_o
   );
endinterface

// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl
//   Sequences the CPU data-memory port between the MEM1 issue stage and an
//   SRAM-like data bus. One request at a time is registered and held on the
//   bus until addr_ok; up to MAX_OUTST address-accepted requests may await
//   data_ok. A flush marks every in-flight access as cancelled so MEM2 only
//   sees responses belonging to live instructions.
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : dmem_req_ctrl_if.master (MEM1 request, flush, data bus, MEM2 response, busy)
// Parameters
//   MAX_OUTST : max requests past addr_ok still awaiting data_ok (1..3)
//   CNT_W     : width of the outstanding/cancel counters, must hold MAX_OUTST
// Configuration
//   DMEM_CTRL_RDATA_REG_EN : when defined, data_data_ok_o/mem_rdata_o are
//   registered (1-cycle latency); otherwise they are combinational.
module dmem_req_ctrl #(
   parameter int MAX_OUTST = 2,
   parameter int CNT_W     = 2
) (
   input logic             clk,
   input logic             rst,
   dmem_req_ctrl_if.master bus
);
   typedef enum logic {IDLE = 1'b0, WAIT_ADDR = 1'b1} state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] outst, outst_d;
   logic [CNT_W-1:0] cancel_cnt, cancel_d;
   logic             pend_cancel, pend_cancel_d;
   logic             accept;
   logic             addr_hs;
   logic             rsp_valid;
   logic             rsp_drop;
   logic             rsp_live;

   assign bus.mem1_req_ready_o = !bus.flush_i && (state_q == IDLE) && (outst < MAX_CNT);
   assign accept    = bus.mem1_req_valid_i && bus.mem1_req_ready_o;
   // The bus request is exactly the WAIT_ADDR state.
   assign bus.data_req_o = (state_q == WAIT_ADDR);
   assign addr_hs   = bus.data_req_o && bus.data_addr_ok_i;
   // A data_ok with nothing outstanding is a stray and is ignored entirely.
   assign rsp_valid = bus.data_data_ok_i && (outst != '0);
   assign rsp_drop  = rsp_valid && (cancel_cnt != '0);
   assign rsp_live  = rsp_valid && (cancel_cnt == '0) && !bus.flush_i;
   assign bus.busy_o = bus.data_req_o || (outst != '0) || (cancel_cnt != '0);

   always_comb begin
      state_d       = state_q;
      pend_cancel_d = pend_cancel;
      cancel_d      = cancel_cnt;
      unique case (state_q)
         IDLE:      if (accept) state_d = WAIT_ADDR;
         WAIT_ADDR: if (bus.data_addr_ok_i) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
      outst_d = outst + CNT_W'(addr_hs) - CNT_W'(rsp_valid);
      if (rsp_drop) cancel_d = cancel_cnt - CNT_W'(1);
      // A request flushed while waiting for addr_ok becomes a cancelled
      // outstanding request the moment the bus finally accepts it.
      if (addr_hs && pend_cancel) begin
         cancel_d      = cancel_d + CNT_W'(1);
         pend_cancel_d = 1'b0;
      end
      // Flush: every request that will be outstanding next cycle is dead.
      if (bus.flush_i) begin
         cancel_d = outst_d;
         if ((state_q == WAIT_ADDR) && !bus.data_addr_ok_i) pend_cancel_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         outst       <= '0;
         cancel_cnt  <= '0;
         pend_cancel <= 1'b0;
      end else begin
         state_q     <= state_d;
         outst       <= outst_d;
         cancel_cnt  <= cancel_d;
         pend_cancel <= pend_cancel_d;
      end
   end

   // Request capture: fields stay frozen on the bus until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.data_wr_o    <= 1'b0;
         bus.data_size_o  <= '0;
         bus.data_addr_o  <= '0;
         bus.data_wstrb_o <= '0;
         bus.data_wdata_o <= '0;
      end else if (accept) begin
         bus.data_wr_o    <= bus.mem1_req_wr_i;
         bus.data_size_o  <= bus.mem1_req_size_i;
         bus.data_addr_o  <= bus.mem1_req_addr_i;
         bus.data_wstrb_o <= bus.mem1_req_wstrb_i;
         bus.data_wdata_o <= bus.mem1_req_wdata_i;
      end
   end

`ifdef DMEM_CTRL_RDATA_REG_EN
   logic        rsp_vld_p1;
   logic [31:0] rsp_rdata_p1;

   // Response register stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_vld_p1   <= 1'b0;
         rsp_rdata_p1 <= '0;
      end else begin
         rsp_vld_p1   <= rsp_live;
         rsp_rdata_p1 <= bus.data_rdata_i;
      end
   end

   // A flush also kills the response already sitting in the register.
   assign bus.data_data_ok_o = rsp_vld_p1 && !bus.flush_i;
   assign bus.mem_rdata_o    = rsp_rdata_p1;
`else
   assign bus.data_data_ok_o = rsp_live;
   assign bus.mem_rdata_o    = bus.data_rdata_i;
`endif
endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb_dmem_req_ctrl
//   Directed bench for dmem_req_ctrl (default build, combinational response).
//   Inputs change 1 time unit after the rising edge; outputs are checked 3
//   time units after the rising edge.
module tb_dmem_req_ctrl;
   localparam int MAX_OUTST = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   dmem_req_ctrl_if bif ();

   dmem_req_ctrl #(.MAX_OUTST(MAX_OUTST), .CNT_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                      input logic [3:0] wstrb, input logic [31:0] wdata);
      bif.mem1_req_valid_i = 1'b1;
      bif.mem1_req_wr_i    = wr;
      bif.mem1_req_size_i  = size;
      bif.mem1_req_addr_i  = addr;
      bif.mem1_req_wstrb_i = wstrb;
      bif.mem1_req_wdata_i = wdata;
   endtask

   // cancel_cnt <= outst <= MAX_OUTST at all times out of reset.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         assert ((dut.cancel_cnt <= dut.outst) && (dut.outst <= 2'(MAX_OUTST))) else begin
            failures++;
            $error("FAIL invariant cancel=%0d outst=%0d max=%0d", dut.cancel_cnt, dut.outst, MAX_OUTST);
         end
      end
   end

   initial begin
      rst = 1'b1;
      bif.mem1_req_valid_i = 1'b0;
      bif.mem1_req_wr_i    = 1'b0;
      bif.mem1_req_size_i  = 2'd0;
      bif.mem1_req_addr_i  = '0;
      bif.mem1_req_wstrb_i = '0;
      bif.mem1_req_wdata_i = '0;
      bif.flush_i          = 1'b0;
      bif.data_addr_ok_i   = 1'b0;
      bif.data_data_ok_i   = 1'b0;
      bif.data_rdata_i     = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #3;
      chk("rst_req",    bif.data_req_o, 0);
      chk("rst_wr",     bif.data_wr_o, 0);
      chk("rst_addr",   bif.data_addr_o, 0);
      chk("rst_wstrb",  bif.data_wstrb_o, 0);
      chk("rst_wdata",  bif.data_wdata_o, 0);
      chk("rst_dok",    bif.data_data_ok_o, 0);
      chk("rst_rdata",  bif.mem_rdata_o, 0);
      chk("rst_busy",   bif.busy_o, 0);
      chk("rst_outst",  dut.outst, 0);
      chk("rst_cancel", dut.cancel_cnt, 0);
      cyc(); rst = 1'b0; #2;
      chk("rst_ready", bif.mem1_req_ready_o, 1);

      // T1: single load, addr_ok at N+2, data_ok at N+4
      cyc(); req(1'b0, 2'd2, 32'h100, 4'h0, 32'h0); #2;
      chk("t1_ready_n", bif.mem1_req_ready_o, 1);
      cyc(); bif.mem1_req_valid_i = 1'b0; #2;
      chk("t1_req_n1",   bif.data_req_o, 1);
      chk("t1_addr_n1",  bif.data_addr_o, 32'h100);
      chk("t1_wr_n1",    bif.data_wr_o, 0);
      chk("t1_size_n1",  bif.data_size_o, 2);
      chk("t1_ready_n1", bif.mem1_req_ready_o, 0);
      cyc(); bif.data_addr_ok_i = 1'b1; #2;
      chk("t1_req_n2", bif.data_req_o, 1);
      cyc(); bif.data_addr_ok_i = 1'b0; #2;
      chk("t1_req_n3",   bif.data_req_o, 0);
      chk("t1_outst_n3", dut.outst, 1);
      chk("t1_busy_n3",  bif.busy_o, 1);
      chk("t1_dok_n3",   bif.data_data_ok_o, 0);
      cyc(); bif.data_data_ok_i = 1'b1; bif.data_rdata_i = 32'hDEADBEEF; #2;
      chk("t1_dok_n4",   bif.data_data_ok_o, 1);
      chk("t1_rdata_n4", bif.mem_rdata_o, 32'hDEADBEEF);
      cyc(); bif.data_data_ok_i = 1'b0; bif.data_rdata_i = '0; #2;
      chk("t1_outst_end", dut.outst, 0);
      chk("t1_busy_end",  bif.busy_o, 0);
      chk("t1_dok_end",   bif.data_data_ok_o, 0);

      // T2: three back-to-back loads, data_ok withheld
      cyc(); req(1'b0, 2'd2, 32'h200, 4'h0, 32'h0); #2;
      chk("t2_ready_a", bif.mem1_req_ready_o, 1);
      cyc(); bif.data_addr_ok_i = 1'b1; bif.mem1_req_addr_i = 32'h204; #2;
      chk("t2_ready_a1", bif.mem1_req_ready_o, 0);
      chk("t2_addr_a1",  bif.data_addr_o, 32'h200);
      cyc(); bif.data_addr_ok_i = 1'b0; #2;
      chk("t2_ready_a2", bif.mem1_req_ready_o, 1);
      cyc(); bif.data_addr_ok_i = 1'b1; bif.mem1_req_addr_i = 32'h208; #2;
      chk("t2_addr_a3",  bif.data_addr_o, 32'h204);
      chk("t2_ready_a3", bif.mem1_req_ready_o, 0);
      cyc(); bif.data_addr_ok_i = 1'b0; #2;
      chk("t2_outst_a4", dut.outst, 2);
      chk("t2_ready_a4", bif.mem1_req_ready_o, 0);
      cyc(); #2;
      chk("t2_ready_a5", bif.mem1_req_ready_o, 0);
      cyc(); bif.data_data_ok_i = 1'b1; bif.data_rdata_i = 32'h11; #2;
      chk("t2_dok_a6",   bif.data_data_ok_o, 1);
      chk("t2_rdata_a6", bif.mem_rdata_o, 32'h11);
      chk("t2_ready_a6", bif.mem1_req_ready_o, 0);
      cyc(); bif.data_data_ok_i = 1'b0; #2;
      chk("t2_ready_a7", bif.mem1_req_ready_o, 1);
      chk("t2_outst_a7", dut.outst, 1);
      cyc(); bif.mem1_req_valid_i = 1'b0; bif.data_addr_ok_i = 1'b1; #2;
      chk("t2_addr_a8", bif.data_addr_o, 32'h208);
      chk("t2_req_a8",  bif.data_req_o, 1);
      cyc(); bif.data_addr_ok_i = 1'b0; bif.data_data_ok_i = 1'b1; bif.data_rdata_i = 32'h22; #2;
      chk("t2_outst_a9", dut.outst, 2);
      chk("t2_dok_a9",   bif.data_data_ok_o, 1);
      chk("t2_rdata_a9", bif.mem_rdata_o, 32'h22);
      cyc(); bif.data_rdata_i = 32'h33; #2;
      chk("t2_dok_a10",   bif.data_data_ok_o, 1);
      chk("t2_rdata_a10", bif.mem_rdata_o, 32'h33);
      chk("t2_outst_a10", dut.outst, 1);
      cyc(); bif.data_data_ok_i = 1'b0; bif.data_rdata_i = '0; #2;
      chk("t2_outst_end", dut.outst, 0);
      chk("t2_busy_end",  bif.busy_o, 0);

      // T3: store, fields held until addr_ok while MEM1 inputs change
      cyc(); req(1'b1, 2'd1, 32'h300, 4'b0011, 32'h1234); #2;
      chk("t3_ready", bif.mem1_req_ready_o, 1);
      cyc(); req(1'b0, 2'd0, 32'h999, 4'hF, 32'hFFFF_FFFF); bif.mem1_req_valid_i = 1'b0; #2;
      chk("t3_wr",    bif.data_wr_o, 1);
      chk("t3_wstrb", bif.data_wstrb_o, 4'b0011);
      chk("t3_wdata", bif.data_wdata_o, 32'h1234);
      chk("t3_addr",  bif.data_addr_o, 32'h300);
      chk("t3_size",  bif.data_size_o, 1);
      for (int i = 0; i < 2; i++) begin
         cyc(); #2;
         chk("t3_hold_req",   bif.data_req_o, 1);
         chk("t3_hold_wstrb", bif.data_wstrb_o, 4'b0011);
         chk("t3_hold_wdata", bif.data_wdata_o, 32'h1234);
      end
      cyc(); bif.data_addr_ok_i = 1'b1; #2;
      chk("t3_hs_wdata", bif.data_wdata_o, 32'h1234);
      cyc(); bif.data_addr_ok_i = 1'b0; #2;
      chk("t3_req_off", bif.data_req_o, 0);
      chk("t3_outst",   dut.outst, 1);
      cyc(); bif.data_data_ok_i = 1'b1; #2;
      chk("t3_dok", bif.data_data_ok_o, 1);
      cyc(); bif.data_data_ok_i = 1'b0; #2;
      chk("t3_busy_end", bif.busy_o, 0);
      bif.mem1_req_wstrb_i = '0;
      bif.mem1_req_wdata_i = '0;

      // T4: two outstanding loads flushed, then a normal load
      cyc(); req(1'b0, 2'd2, 32'h400, 4'h0, 32'h0); #2;
      cyc(); bif.mem1_req_valid_i = 1'b0; bif.data_addr_ok_i = 1'b1; #2;
      cyc(); bif.data_addr_ok_i = 1'b0; req(1'b0, 2'd2, 32'h404, 4'h0, 32'h0); #2;
      chk("t4_ready_2nd", bif.mem1_req_ready_o, 1);
      cyc(); bif.mem1_req_valid_i = 1'b0; bif.data_addr_ok_i = 1'b1; #2;
      cyc(); bif.data_addr_ok_i = 1'b0; bif.flush_i = 1'b1; #2;
      chk("t4_outst_f", dut.outst, 2);
      chk("t4_dok_f",   bif.data_data_ok_o, 0);
      cyc(); bif.flush_i = 1'b0; #2;
      chk("t4_cancel_f1", dut.cancel_cnt, 2);
      chk("t4_outst_f1",  dut.outst, 2);
      chk("t4_busy_f1",   bif.busy_o, 1);
      cyc(); bif.data_data_ok_i = 1'b1; bif.data_rdata_i = 32'hBAD1; #2;
      chk("t4_drop1", bif.data_data_ok_o, 0);
      cyc(); bif.data_rdata_i = 32'hBAD2; #2;
      chk("t4_drop2",   bif.data_data_ok_o, 0);
      chk("t4_cancel1", dut.cancel_cnt, 1);
      cyc(); bif.data_data_ok_i = 1'b0; bif.data_rdata_i = '0; #2;
      chk("t4_cancel0", dut.cancel_cnt, 0);
      chk("t4_outst0",  dut.outst, 0);
      chk("t4_busy0",   bif.busy_o, 0);
      cyc(); req(1'b0, 2'd2, 32'h408, 4'h0, 32'h0); #2;
      cyc(); bif.mem1_req_valid_i = 1'b0; bif.data_addr_ok_i = 1'b1; #2;
      cyc(); bif.data_addr_ok_i = 1'b0; bif.data_data_ok_i = 1'b1; bif.data_rdata_i = 32'hCAFEF00D; #2;
      chk("t4_live_dok",   bif.data_data_ok_o, 1);
      chk("t4_live_rdata", bif.mem_rdata_o, 32'hCAFEF00D);
      cyc(); bif.data_data_ok_i = 1'b0; bif.data_rdata_i = '0; #2;
      chk("t4_outst_end", dut.outst, 0);

      // T5: flush while waiting for addr_ok, addr_ok 3 cycles later
      cyc(); req(1'b0, 2'd2, 32'h500, 4'h0, 32'h0); #2;
      cyc(); bif.mem1_req_valid_i = 1'b0; bif.flush_i = 1'b1; #2;
      chk("t5_req_f", bif.data_req_o, 1);
      cyc(); bif.flush_i = 1'b0; #2;
      chk("t5_req_f1",  bif.data_req_o, 1);
      chk("t5_addr_f1", bif.data_addr_o, 32'h500);
      chk("t5_busy_f1", bif.busy_o, 1);
      chk("t5_pend_f1", dut.pend_cancel, 1);
      cyc(); #2;
      chk("t5_req_f2", bif.data_req_o, 1);
      cyc(); bif.data_addr_ok_i = 1'b1; #2;
      cyc(); bif.data_addr_ok_i = 1'b0; #2;
      chk("t5_req_f4",    bif.data_req_o, 0);
      chk("t5_outst_f4",  dut.outst, 1);
      chk("t5_cancel_f4", dut.cancel_cnt, 1);
      chk("t5_busy_f4",   bif.busy_o, 1);
      cyc(); bif.data_data_ok_i = 1'b1; bif.data_rdata_i = 32'h55; #2;
      chk("t5_drop",    bif.data_data_ok_o, 0);
      chk("t5_busy_f5", bif.busy_o, 1);
      cyc(); bif.data_data_ok_i = 1'b0; bif.data_rdata_i = '0; #2;
      chk("t5_busy_end",   bif.busy_o, 0);
      chk("t5_cancel_end", dut.cancel_cnt, 0);

      // Flush while idle with nothing outstanding: no accept, no state change
      cyc(); req(1'b0, 2'd2, 32'h700, 4'h0, 32'h0); bif.flush_i = 1'b1; #2;
      chk("fi_ready", bif.mem1_req_ready_o, 0);
      cyc(); bif.flush_i = 1'b0; bif.mem1_req_valid_i = 1'b0; #2;
      chk("fi_req",    bif.data_req_o, 0);
      chk("fi_busy",   bif.busy_o, 0);
      chk("fi_cancel", dut.cancel_cnt, 0);

      // T6: asynchronous reset mid-transaction, then a stray data_ok
      cyc(); req(1'b0, 2'd2, 32'h600, 4'h0, 32'h0); #2;
      cyc(); bif.mem1_req_valid_i = 1'b0; bif.data_addr_ok_i = 1'b1; #2;
      cyc(); bif.data_addr_ok_i = 1'b0; req(1'b0, 2'd2, 32'h604, 4'h0, 32'h0); #2;
      chk("t6_outst", dut.outst, 1);
      cyc(); bif.mem1_req_valid_i = 1'b0; #2;
      chk("t6_req_pend", bif.data_req_o, 1);
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_req",   bif.data_req_o, 0);
      chk("t6_rst_addr",  bif.data_addr_o, 0);
      chk("t6_rst_busy",  bif.busy_o, 0);
      chk("t6_rst_outst", dut.outst, 0);
      chk("t6_rst_dok",   bif.data_data_ok_o, 0);
      chk("t6_rst_rdata", bif.mem_rdata_o, 0);
      cyc(); rst = 1'b0; bif.data_data_ok_i = 1'b1; bif.data_rdata_i = 32'h77; #2;
      chk("t6_stray_dok",  bif.data_data_ok_o, 0);
      chk("t6_stray_busy", bif.busy_o, 0);
      cyc(); bif.data_data_ok_i = 1'b0; bif.data_rdata_i = '0; #2;
      chk("t6_outst_end", dut.outst, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
